// File: rtl/pipelined_barrel_shifter.sv
// pipelined_barrel_shifter: log2(WIDTH)-level barrel shifter split into PIPE_STAGES valid/ready register groups.
// Ports:
//   clk, rst_n                          clock, asynchronous active-low reset
//   flush                               synchronous clear of every stage-valid bit
//   in_valid/in_ready                   input handshake
//   in_data, in_amt, in_op, in_tag      operand, shift amount, op (00 SLL, 01 SRL, 10 SRA, 11 ROR), sideband tag
//   out_valid/out_ready                 output handshake
//   out_data, out_tag                   result and its tag
//   occupancy                           number of valid stages
// Macro SHIFTER_ROTATE_EN: when defined op 11 rotates right; otherwise op 11 behaves as SRL.
module pipelined_barrel_shifter #(
    parameter int WIDTH       = 32,
    parameter int PIPE_STAGES = 2,
    parameter int TAG_W       = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          flush,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [WIDTH-1:0]              in_data,
    input  logic [$clog2(WIDTH)-1:0]      in_amt,
    input  logic [1:0]                    in_op,
    input  logic [TAG_W-1:0]              in_tag,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [WIDTH-1:0]              out_data,
    output logic [TAG_W-1:0]              out_tag,
    output logic [$clog2(PIPE_STAGES):0]  occupancy
);
    localparam int LOG   = $clog2(WIDTH);
    localparam int BASE  = LOG / PIPE_STAGES;
    localparam int EXTRA = LOG % PIPE_STAGES;
    localparam int OCC_W = $clog2(PIPE_STAGES) + 1;
    localparam logic [WIDTH-1:0] ONES = '1;

    logic [PIPE_STAGES-1:0] r_valid;
    logic [WIDTH-1:0]       r_data [PIPE_STAGES];
    logic [LOG-1:0]         r_amt  [PIPE_STAGES];
    logic [1:0]             r_op   [PIPE_STAGES];
    logic [TAG_W-1:0]       r_tag  [PIPE_STAGES];

    logic [PIPE_STAGES-1:0] w_adv;
    logic [PIPE_STAGES-1:0] w_src_valid;
    logic [WIDTH-1:0]       w_src_data [PIPE_STAGES];
    logic [LOG-1:0]         w_src_amt  [PIPE_STAGES];
    logic [1:0]             w_src_op   [PIPE_STAGES];
    logic [TAG_W-1:0]       w_src_tag  [PIPE_STAGES];
    logic [WIDTH-1:0]       w_res      [PIPE_STAGES];

    // First binary level owned by group g; earlier groups absorb the remainder.
    function automatic int grp_lo(input int g);
        return g * BASE + (g < EXTRA ? g : EXTRA);
    endfunction

    // One binary level shifting right/left by s. SRA keeps the MSB at every level,
    // so replicating the current MSB equals replicating the original sign bit.
    function automatic logic [WIDTH-1:0] step(input logic [WIDTH-1:0] d, input logic [1:0] op, input int s);
        logic [WIDTH-1:0] w_fill;
`ifdef SHIFTER_ROTATE_EN
        w_fill = op == 2'b10 ? {WIDTH{d[WIDTH-1]}} & ~(ONES >> s) : op == 2'b11 ? d << (WIDTH - s) : '0;
`else
        w_fill = op == 2'b10 ? {WIDTH{d[WIDTH-1]}} & ~(ONES >> s) : '0;
`endif
        return op == 2'b00 ? d << s : (d >> s) | w_fill;
    endfunction

    // Stage g moves unless it and every later stage are full while the consumer stalls.
    for (genvar g = 0; g < PIPE_STAGES; g++) begin : g_adv
        assign w_adv[g] = out_ready || !(&r_valid[PIPE_STAGES-1:g]);
    end

    assign in_ready  = w_adv[0] && !flush;
    assign out_valid = r_valid[PIPE_STAGES-1];
    assign out_data  = r_data[PIPE_STAGES-1];
    assign out_tag   = r_tag[PIPE_STAGES-1];

    always_comb begin
        w_src_valid[0] = in_valid;
        w_src_data[0]  = in_data;
        w_src_amt[0]   = in_amt;
        w_src_op[0]    = in_op;
        w_src_tag[0]   = in_tag;
        for (int g = 1; g < PIPE_STAGES; g++) begin
            w_src_valid[g] = r_valid[g-1];
            w_src_data[g]  = r_data[g-1];
            w_src_amt[g]   = r_amt[g-1];
            w_src_op[g]    = r_op[g-1];
            w_src_tag[g]   = r_tag[g-1];
        end
        for (int g = 0; g < PIPE_STAGES; g++) begin
            w_res[g] = w_src_data[g];
            for (int k = grp_lo(g); k < grp_lo(g + 1); k++)
                if (w_src_amt[g][k]) w_res[g] = step(w_res[g], w_src_op[g], 1 << k);
        end
    end

    always_comb begin
        occupancy = '0;
        for (int g = 0; g < PIPE_STAGES; g++)
            occupancy = occupancy + OCC_W'(r_valid[g]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_valid <= '0;
        else if (flush)
            r_valid <= '0;
        else
            for (int g = 0; g < PIPE_STAGES; g++)
                if (w_adv[g]) r_valid[g] <= w_src_valid[g];
    end

    always_ff @(posedge clk) begin
        for (int g = 0; g < PIPE_STAGES; g++) begin
            if (w_adv[g]) begin
                r_data[g] <= w_res[g];
                r_amt[g]  <= w_src_amt[g];
                r_op[g]   <= w_src_op[g];
                r_tag[g]  <= w_src_tag[g];
            end
        end
    end
endmodule

// File: tb/tb_pipelined_barrel_shifter.sv
// tb_pipelined_barrel_shifter: randomized and directed checks of pipelined_barrel_shifter against a behavioural model.
module tb_pipelined_barrel_shifter;
    localparam int W  = 32;
    localparam int P  = 2;
    localparam int TW = 4;
    localparam int AW = 5;

    typedef struct { logic [W-1:0] d; logic [TW-1:0] t; int cyc; } op_t;

    logic          clk = 0, rst_n = 1, flush = 0, in_valid = 0, out_ready = 0;
    logic          in_ready, out_valid;
    logic [W-1:0]  in_data = '0, out_data;
    logic [AW-1:0] in_amt = '0;
    logic [1:0]    in_op = '0;
    logic [TW-1:0] in_tag = '0, out_tag;
    logic [1:0]    occupancy;

    int checks = 0, passes = 0, cyc = 0;
    op_t           q_exp [$];
    logic [W-1:0]  got_d [$], exp_d [$];
    logic [TW-1:0] got_t [$], exp_t [$];
    int            lat [$];

    pipelined_barrel_shifter #(.WIDTH(W), .PIPE_STAGES(P), .TAG_W(TW)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_amt(in_amt), .in_op(in_op), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_tag(out_tag),
        .occupancy(occupancy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [W-1:0] model(input logic [W-1:0] d, input int a, input logic [1:0] op);
        logic [2*W-1:0] w;
        w = op == 2'b10 ? {{W{d[W-1]}}, d} >> a : {d, d} >> a;
        if (op == 2'b00) return d << a;
        if (op == 2'b01) return d >> a;
`ifndef SHIFTER_ROTATE_EN
        if (op == 2'b11) return d >> a;
`endif
        return w[W-1:0];
    endfunction

    // Called at a falling edge: samples handshakes mid-cycle, updates the in-flight model, advances one cycle.
    task automatic tick(output bit acc);
        op_t e;
        #3;
        acc = 0;
        if (flush) q_exp.delete();
        else begin
            if (out_valid && out_ready) begin
                got_d.push_back(out_data);
                got_t.push_back(out_tag);
                if (q_exp.size() > 0) begin
                    e = q_exp.pop_front();
                    exp_d.push_back(e.d);
                    exp_t.push_back(e.t);
                    lat.push_back(cyc - e.cyc);
                end else begin
                    exp_d.push_back('x);
                    exp_t.push_back('x);
                    lat.push_back(-1);
                end
            end
            if (in_valid && in_ready) begin
                q_exp.push_back('{model(in_data, int'(in_amt), in_op), in_tag, cyc});
                acc = 1;
            end
        end
        @(negedge clk);
    endtask

    task automatic send(input logic [W-1:0] d, input int a, input logic [1:0] op, input logic [TW-1:0] t);
        bit acc = 0;
        in_valid = 1; in_data = d; in_amt = AW'(a); in_op = op; in_tag = t;
        for (int i = 0; i < 20 && !acc; i++) tick(acc);
    endtask

    task automatic drain(input int n);
        bit acc;
        in_valid = 0;
        repeat (n) tick(acc);
    endtask

    task automatic clear_log();
        got_d.delete(); got_t.delete(); exp_d.delete(); exp_t.delete(); lat.delete();
    endtask

    task automatic test_reset();
        #1 rst_n = 0;
        #2;
        checks++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b expected 0", out_valid); else passes++;
        checks++; if (occupancy !== 2'd0) $display("FAIL reset_occupancy: got %0d expected 0", occupancy); else passes++;
        repeat (2) @(negedge clk);
        rst_n = 1;
        #1;
        checks++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b expected 1", in_ready); else passes++;
        @(negedge clk);
    endtask

    task automatic test_directed();
        logic [W-1:0] want [4];
        want[0] = 32'h8000_0000; want[1] = 32'hF800_0001; want[2] = 32'h0800_0001;
`ifdef SHIFTER_ROTATE_EN
        want[3] = 32'h1000_000F;
`else
        want[3] = 32'h0000_000F;
`endif
        clear_log();
        out_ready = 1;
        send(32'h0000_0001, 31, 2'b00, 4'h5);
        send(32'h8000_0010, 4, 2'b10, 4'h6);
        send(32'h8000_0010, 4, 2'b01, 4'h7);
        send(32'h0000_00F1, 4, 2'b11, 4'h8);
        drain(6);
        checks++; if (got_d.size() != 4) $display("FAIL directed_count: got %0d expected 4", got_d.size()); else passes++;
        for (int i = 0; i < got_d.size() && i < 4; i++) begin
            checks++; if (got_d[i] !== want[i]) $display("FAIL directed_data[%0d]: got %h expected %h", i, got_d[i], want[i]); else passes++;
            checks++; if (got_t[i] !== TW'(5 + i)) $display("FAIL directed_tag[%0d]: got %h expected %h", i, got_t[i], 5 + i); else passes++;
            checks++; if (lat[i] != 2) $display("FAIL directed_latency[%0d]: got %0d expected 2", i, lat[i]); else passes++;
        end
    endtask

    task automatic test_amt_zero();
        logic [W-1:0] d [4];
        clear_log();
        out_ready = 1;
        for (int i = 0; i < 4; i++) begin
            d[i] = $urandom;
            send(d[i], 0, 2'(i), TW'(i));
        end
        drain(5);
        checks++; if (got_d.size() != 4) $display("FAIL amt0_count: got %0d expected 4", got_d.size()); else passes++;
        for (int i = 0; i < got_d.size() && i < 4; i++) begin
            checks++; if (got_d[i] !== d[i]) $display("FAIL amt0_data[%0d]: got %h expected %h", i, got_d[i], d[i]); else passes++;
        end
    endtask

    task automatic test_random();
        bit acc = 0;
        int n_acc = 0;
        clear_log();
        for (int c = 0; c < 300; c++) begin
            if (!in_valid || acc) begin
                in_valid = $urandom_range(0, 9) < 7;
                in_data  = $urandom;
                in_amt   = AW'($urandom_range(0, W - 1));
                in_op    = 2'($urandom_range(0, 3));
                in_tag   = TW'($urandom);
            end
            out_ready = $urandom_range(0, 9) < 7;
            tick(acc);
            n_acc += int'(acc);
            checks++; if (int'(occupancy) !== q_exp.size()) $display("FAIL random_occupancy: got %0d expected %0d", occupancy, q_exp.size()); else passes++;
        end
        out_ready = 1;
        drain(6);
        checks++; if (got_d.size() != n_acc) $display("FAIL random_count: got %0d expected %0d", got_d.size(), n_acc); else passes++;
        for (int i = 0; i < got_d.size(); i++) begin
            checks++; if (got_d[i] !== exp_d[i]) $display("FAIL random_data[%0d]: got %h expected %h", i, got_d[i], exp_d[i]); else passes++;
            checks++; if (got_t[i] !== exp_t[i]) $display("FAIL random_tag[%0d]: got %h expected %h", i, got_t[i], exp_t[i]); else passes++;
        end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0]  bd [4], hold_d;
        logic [4:0]    ba [4];
        logic [1:0]    bo [4];
        logic [TW-1:0] hold_t;
        bit acc;
        int n_acc = 0;
        clear_log();
        for (int i = 0; i < 4; i++) begin
            bd[i] = $urandom; ba[i] = 5'($urandom); bo[i] = 2'($urandom);
        end
        out_ready = 0;
        for (int c = 0; c < 6; c++) begin
            in_valid = n_acc < 4;
            in_data = bd[n_acc % 4]; in_amt = ba[n_acc % 4]; in_op = bo[n_acc % 4]; in_tag = TW'(n_acc);
            tick(acc);
            n_acc += int'(acc);
        end
        checks++; if (n_acc != 2) $display("FAIL b2b_accepted: got %0d expected 2", n_acc); else passes++;
        checks++; if (in_ready !== 1'b0) $display("FAIL b2b_in_ready: got %b expected 0", in_ready); else passes++;
        checks++; if (occupancy !== 2'd2) $display("FAIL b2b_occupancy: got %0d expected 2", occupancy); else passes++;
        hold_d = out_data; hold_t = out_tag;
        for (int c = 0; c < 2; c++) begin
            tick(acc);
            checks++; if (out_data !== hold_d) $display("FAIL b2b_hold_data: got %h expected %h", out_data, hold_d); else passes++;
            checks++; if (out_tag !== hold_t) $display("FAIL b2b_hold_tag: got %h expected %h", out_tag, hold_t); else passes++;
        end
        out_ready = 1;
        for (int c = 0; c < 20 && got_d.size() < 4; c++) begin
            in_valid = n_acc < 4;
            in_data = bd[n_acc % 4]; in_amt = ba[n_acc % 4]; in_op = bo[n_acc % 4]; in_tag = TW'(n_acc);
            tick(acc);
            n_acc += int'(acc);
        end
        drain(4);
        checks++; if (got_d.size() != 4) $display("FAIL b2b_count: got %0d expected 4", got_d.size()); else passes++;
        for (int i = 0; i < got_d.size(); i++) begin
            checks++; if (got_t[i] !== TW'(i)) $display("FAIL b2b_order[%0d]: got %h expected %h", i, got_t[i], i); else passes++;
            checks++; if (got_d[i] !== model(bd[i % 4], int'(ba[i % 4]), bo[i % 4])) $display("FAIL b2b_data[%0d]: got %h expected %h", i, got_d[i], model(bd[i % 4], int'(ba[i % 4]), bo[i % 4])); else passes++;
        end
    endtask

    task automatic test_flush();
        bit acc;
        clear_log();
        out_ready = 0;
        send($urandom, 3, 2'b00, 4'h1);
        send($urandom, 7, 2'b01, 4'h2);
        checks++; if (occupancy !== 2'd2) $display("FAIL flush_pre_occupancy: got %0d expected 2", occupancy); else passes++;
        flush = 1; out_ready = 1; in_valid = 1; in_data = $urandom; in_tag = 4'h3;
        tick(acc);
        flush = 0;
        checks++; if (occupancy !== 2'd0) $display("FAIL flush_occupancy: got %0d expected 0", occupancy); else passes++;
        checks++; if (out_valid !== 1'b0) $display("FAIL flush_out_valid: got %b expected 0", out_valid); else passes++;
        checks++; if (got_d.size() != 0) $display("FAIL flush_outputs: got %0d expected 0", got_d.size()); else passes++;
        in_data = $urandom; in_amt = 5'd9; in_op = 2'b10; in_tag = 4'h9;
        tick(acc);
        checks++; if (acc !== 1'b1) $display("FAIL flush_resume_accept: got %b expected 1", acc); else passes++;
        drain(5);
        checks++; if (got_d.size() != 1) $display("FAIL flush_resume_count: got %0d expected 1", got_d.size()); else passes++;
        if (got_d.size() > 0) begin
            checks++; if (got_t[0] !== 4'h9) $display("FAIL flush_resume_tag: got %h expected 9", got_t[0]); else passes++;
            checks++; if (got_d[0] !== exp_d[0]) $display("FAIL flush_resume_data: got %h expected %h", got_d[0], exp_d[0]); else passes++;
        end
    endtask

    task automatic test_reset_mid();
        bit acc;
        out_ready = 1;
        for (int c = 0; c < 3; c++) begin
            in_valid = 1; in_data = $urandom; in_amt = 5'($urandom); in_op = 2'($urandom); in_tag = TW'(c);
            tick(acc);
        end
        #2 rst_n = 0;
        #1;
        checks++; if (out_valid !== 1'b0) $display("FAIL midreset_out_valid: got %b expected 0", out_valid); else passes++;
        checks++; if (occupancy !== 2'd0) $display("FAIL midreset_occupancy: got %0d expected 0", occupancy); else passes++;
        q_exp.delete();
        in_valid = 0;
        @(negedge clk);
        rst_n = 1;
        clear_log();
        #1;
        checks++; if (in_ready !== 1'b1) $display("FAIL midreset_in_ready: got %b expected 1", in_ready); else passes++;
        send(32'h8000_0010, 4, 2'b10, 4'hA);
        drain(5);
        checks++; if (got_d.size() != 1) $display("FAIL midreset_count: got %0d expected 1", got_d.size()); else passes++;
        if (got_d.size() > 0) begin
            checks++; if (got_d[0] !== 32'hF800_0001) $display("FAIL midreset_data: got %h expected f8000001", got_d[0]); else passes++;
            checks++; if (lat[0] != 2) $display("FAIL midreset_latency: got %0d expected 2", lat[0]); else passes++;
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_amt_zero();
        test_back_to_back();
        test_flush();
        test_random();
        test_reset_mid();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule

// File: doc/pipelined_barrel_shifter.md
PIPELINED_BARREL_SHIFTER -- requirements
Module: pipelined_barrel_shifter

Interface
REQ-001 Parameter WIDTH, default 32: data width in bits; SHALL be a power of two from 8 to 64.
REQ-002 Parameter PIPE_STAGES, default 2: number of register stages; SHALL be 1 to log2(WIDTH).
REQ-003 Parameter TAG_W, default 4: width of the sideband tag carried with each operation.
REQ-004 clk  input  1  rising-edge clock; the only clock.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 flush  input  1  synchronous pipeline clear.
REQ-007 in_valid  input  1  an operation is offered.
REQ-008 in_ready  output  1  an operation is accepted this cycle.
REQ-009 in_data  input  WIDTH  operand.
REQ-010 in_amt  input  log2(WIDTH)  shift amount (unsigned).
REQ-011 in_op  input  2  operation: 00 SLL, 01 SRL, 10 SRA, 11 ROR.
REQ-012 in_tag  input  TAG_W  sideband tag.
REQ-013 out_valid  output  1  a result is presented.
REQ-014 out_ready  input  1  the consumer accepts the result.
REQ-015 out_data  output  WIDTH  result.
REQ-016 out_tag  output  TAG_W  tag of the result.
REQ-017 occupancy  output  log2(PIPE_STAGES)+1  number of valid stages.

Function
REQ-018 The block SHALL implement log2(WIDTH) binary stages; stage k SHALL shift by 2^k when amt[k]=1.
REQ-019 Stages SHALL be partitioned into PIPE_STAGES contiguous groups as evenly as possible, earlier groups taking any extra stage; each group SHALL end in a register holding data, remaining amt bits, op, tag and valid.
REQ-020 Fill bits: SLL and SRL SHALL fill with 0; SRA SHALL fill with in_data[WIDTH-1]; ROR SHALL fill with the bits shifted out at the LSB end.
REQ-021 Latency: a transfer accepted in cycle N with no stall SHALL produce out_valid in cycle N+PIPE_STAGES.
REQ-022 A transfer SHALL occur on each edge where valid and ready are both 1; out_data and out_tag SHALL hold stable while out_valid=1 and out_ready=0.
REQ-023 Stage i SHALL advance when it is empty or stage i+1 advances; the last stage SHALL advance when out_ready=1 or it is empty.
REQ-024 in_ready SHALL equal "stage 0 empty OR stage 0 advances" and SHALL have no combinational path from in_valid.
REQ-025 With no stall, throughput SHALL be one operation per cycle, bubbles SHALL collapse, and results SHALL emerge in acceptance order.
REQ-026 Shift amount 0 SHALL return in_data unchanged for every op.
REQ-027 flush=1 SHALL clear all valid bits on the next edge, and no input SHALL be accepted that cycle; flush SHALL take priority over simultaneous in_valid and out_ready.
REQ-028 occupancy SHALL equal the count of set stage-valid bits after each edge.

Reset
REQ-029 While rst_n=0, all stage-valid bits SHALL be 0, out_valid=0 and occupancy=0, asynchronously.
REQ-030 Datapath registers SHALL NOT require reset; out_data and out_tag are don't-care while out_valid=0.
REQ-031 An assertion of rst_n mid-operation SHALL discard every in-flight operation, and in_ready SHALL be 1 on the first edge after release.

Configuration
REQ-032 Macro SHIFTER_ROTATE_EN: when defined, op 11 SHALL perform rotate-right (ROR).
REQ-033 When SHIFTER_ROTATE_EN is undefined, op 11 SHALL execute as SRL, and no rotate muxing SHALL be synthesised.

Verification
REQ-034 WIDTH=32, PIPE_STAGES=2, out_ready=1; SLL data 0x0000_0001, amt 31 -> out_data 0x8000_0000 exactly 2 cycles later, same tag.
REQ-035 SRA data 0x8000_0010, amt 4 -> 0xF800_0001; SRL with the same operands -> 0x0800_0001.
REQ-036 With SHIFTER_ROTATE_EN defined, ROR data 0x0000_00F1, amt 4 -> 0x1000_000F; with it undefined, the same stimulus -> 0x0000_000F.
REQ-037 Stream 4 ops back-to-back with out_ready=0 -> in_ready drops after 2 accepted and occupancy=2; set out_ready=1 -> all 4 results emerge in order with no loss or duplication.
REQ-038 Assert flush with occupancy=2 and in_valid=1 -> occupancy=0, out_valid=0 and no acceptance on the next edge.
REQ-039 Drive rst_n low mid-stream -> out_valid=0 immediately; after release, the first new op returns after 2 cycles.
